// File: rtl/wb_result_mux_pipe.sv
// N-way write-back result selector with destination sideband, registered through a 2-entry skid buffer.
// Optional select-range checker (sel_err output) enabled by defining WB_RESULT_MUX_SELCHK_EN.
module wb_result_mux_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int REG_AW  = 5,
  localparam int SEL_W  = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic [REG_AW-1:0]        in_rd,
  input  logic                     in_regwrite,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         wb_data,
  output logic [REG_AW-1:0]        wb_rd,
  output logic                     wb_we,
  output logic                     out_valid,
  input  logic                     out_ready
`ifdef WB_RESULT_MUX_SELCHK_EN
  ,
  output logic                     sel_err
`endif
);

  logic              mainValid_q, mainValid_d;
  logic [WIDTH-1:0]  mainData_q, mainData_d;
  logic [REG_AW-1:0] mainRd_q, mainRd_d;
  logic              mainWe_q, mainWe_d;
  logic              skidValid_q, skidValid_d;
  logic [WIDTH-1:0]  skidData_q, skidData_d;
  logic [REG_AW-1:0] skidRd_q, skidRd_d;
  logic              skidWe_q, skidWe_d;

  logic [WIDTH-1:0]  selData;
  logic              inWe;
  logic              accept;
  logic              pop;

  assign accept = in_valid && in_ready;
  assign pop    = mainValid_q && out_ready;

  // Out-of-range selects fall through every compare and leave the data at zero.
  always_comb begin
    selData = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (int'(src_sel) == k) selData = src_data[k*WIDTH +: WIDTH];
    end
  end

`ifdef WB_RESULT_MUX_SELCHK_EN
  logic selOor;
  logic selErr_q;

  assign selOor = (int'(src_sel) >= NUM_SRC);
  assign inWe   = in_regwrite && (in_rd != '0) && !selOor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) selErr_q <= 1'b0;
    else if (accept && selOor) selErr_q <= 1'b1;
  end

  assign sel_err = selErr_q;
`else
  assign inWe = in_regwrite && (in_rd != '0);
`endif

  // Main register refills from the skid first, so ordering stays FIFO.
  always_comb begin
    mainValid_d = mainValid_q;
    mainData_d  = mainData_q;
    mainRd_d    = mainRd_q;
    mainWe_d    = mainWe_q;
    skidValid_d = skidValid_q;
    skidData_d  = skidData_q;
    skidRd_d    = skidRd_q;
    skidWe_d    = skidWe_q;
    if (!mainValid_q || pop) begin
      if (skidValid_q) begin
        mainValid_d = 1'b1;
        mainData_d  = skidData_q;
        mainRd_d    = skidRd_q;
        mainWe_d    = skidWe_q;
        skidValid_d = 1'b0;
      end else if (accept) begin
        mainValid_d = 1'b1;
        mainData_d  = selData;
        mainRd_d    = in_rd;
        mainWe_d    = inWe;
      end else begin
        mainValid_d = 1'b0;
      end
    end else if (accept) begin
      skidValid_d = 1'b1;
      skidData_d  = selData;
      skidRd_d    = in_rd;
      skidWe_d    = inWe;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainValid_q <= 1'b0;
      mainData_q  <= '0;
      mainRd_q    <= '0;
      mainWe_q    <= 1'b0;
      skidValid_q <= 1'b0;
      skidData_q  <= '0;
      skidRd_q    <= '0;
      skidWe_q    <= 1'b0;
    end else begin
      mainValid_q <= mainValid_d;
      mainData_q  <= mainData_d;
      mainRd_q    <= mainRd_d;
      mainWe_q    <= mainWe_d;
      skidValid_q <= skidValid_d;
      skidData_q  <= skidData_d;
      skidRd_q    <= skidRd_d;
      skidWe_q    <= skidWe_d;
    end
  end

  assign in_ready  = !skidValid_q;
  assign out_valid = mainValid_q;
  assign wb_data   = mainData_q;
  assign wb_rd     = mainRd_q;
  assign wb_we     = mainWe_q;

endmodule
